// File: rtl/avalon_master_adapter.sv
// Avalon-MM master adapter: valid/ready command stream in, Avalon read/write
// transfers out, with pipelined reads bounded by MAXPENDING and in-order read responses.
module avalon_master_adapter #(
  parameter int BUSWIDTH     = 32,
  parameter int ADDRESSWIDTH = 8,
  parameter int MAXPENDING   = 4,
  parameter int PENDWIDTH    = $clog2(MAXPENDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_address,
  input  logic [BUSWIDTH-1:0]     cmd_data,
  output logic                    rsp_valid,
  output logic [BUSWIDTH-1:0]     rsp_data,
  output logic                    av_read,
  output logic                    av_write,
  output logic [ADDRESSWIDTH-1:0] av_address,
  output logic [BUSWIDTH-1:0]     av_writedata,
  input  logic                    av_waitrequest,
  input  logic [BUSWIDTH-1:0]     av_readdata,
  input  logic                    av_readdatavalid,
  output logic [PENDWIDTH-1:0]    pending,
  output logic                    protocol_error
);

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_valid and its payload hold until then, and rsp_valid is an unstalled one-cycle pulse.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [PENDWIDTH-1:0] PEND_MAX = PENDWIDTH'(MAXPENDING);
  localparam logic [PENDWIDTH-1:0] PEND_ONE = PENDWIDTH'(1);

  state_t                  state;
  state_t                  state_next;
  logic                    pending_ok;
  logic                    accept;
  logic                    complete;
  logic                    rd_accept;
  logic                    rd_return;
  logic                    read_next;
  logic                    write_next;
  logic [ADDRESSWIDTH-1:0] address_next;
  logic [BUSWIDTH-1:0]     writedata_next;
  logic [PENDWIDTH-1:0]    pending_next;

  always_comb begin
    // A return in the same cycle frees the slot a read at the limit needs.
    pending_ok = (pending < PEND_MAX) || ((pending == PEND_MAX) && av_readdatavalid);
    cmd_ready  = !reset && ((state == IDLE) || !av_waitrequest) && (cmd_write || pending_ok);
    accept     = cmd_valid && cmd_ready;
    complete   = (state == ISSUE) && !av_waitrequest;
    rd_accept  = accept && !cmd_write;
    rd_return  = av_readdatavalid && (pending != '0);

    state_next     = state;
    read_next      = av_read;
    write_next     = av_write;
    address_next   = av_address;
    writedata_next = av_writedata;
    if (accept) begin
      state_next     = ISSUE;
      read_next      = !cmd_write;
      write_next     = cmd_write;
      address_next   = cmd_address;
      writedata_next = cmd_data;
    end else if (complete) begin
      state_next = IDLE;
      read_next  = 1'b0;
      write_next = 1'b0;
    end

    pending_next = pending;
    if (rd_accept && !rd_return) begin
      pending_next = pending + PEND_ONE;
    end else if (rd_return && !rd_accept) begin
      pending_next = pending - PEND_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      av_read      <= 1'b0;
      av_write     <= 1'b0;
      av_address   <= '0;
      av_writedata <= '0;
      pending      <= '0;
    end else begin
      av_read      <= read_next;
      av_write     <= write_next;
      av_address   <= address_next;
      av_writedata <= writedata_next;
      pending      <= pending_next;
    end
  end

  // Read data with nothing outstanding is dropped and latched as a sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      protocol_error <= 1'b0;
    end else begin
      rsp_valid <= rd_return;
      if (rd_return) begin
        rsp_data <= av_readdata;
      end
      if (av_readdatavalid && (pending == '0)) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule

// File: doc/avalon_master_adapter.md
# avalon_master_adapter

Avalon-MM master-side adapter: turns a simple valid/ready command stream into Avalon-MM read/write transfers, honours `av_waitrequest`, supports pipelined reads, and returns read data on a response port. It is the initiator counterpart to the team's fixed-latency register slave adapter. Typical uses are test sequencers, DMA control logic, and CPU-side bridges driving register banks.

## Interface
- `BUSWIDTH`, 32, data width of the command, response and Avalon data buses.
- `ADDRESSWIDTH`, 8, word address width.
- `MAXPENDING`, 4, maximum number of accepted reads whose data has not yet returned (≥1).
- `PENDWIDTH`, `$clog2(MAXPENDING+1)`, width of `pending`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_address`  in  ADDRESSWIDTH  target word address.
- `cmd_data`  in  BUSWIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse; `rsp_data` is valid. There is no backpressure on this port.
- `rsp_data`  out  BUSWIDTH  read data.
- `av_read`, `av_write`  out  1  Avalon read and write strobes.
- `av_address`  out  ADDRESSWIDTH  Avalon address.
- `av_writedata`  out  BUSWIDTH  Avalon write data.
- `av_waitrequest`  in  1  slave stall.
- `av_readdata`  in  BUSWIDTH  slave read data.
- `av_readdatavalid`  in  1  slave read data valid.
- `pending`  out  PENDWIDTH  accepted reads not yet returned.
- `protocol_error`  out  1  sticky; set by `av_readdatavalid` while `pending == 0`.

## Operation
- **States.** Two states:
  - IDLE: no Avalon strobe is asserted.
  - ISSUE: exactly one of `av_read` / `av_write` is high.
- **Acceptance.** A command is accepted when `cmd_valid && cmd_ready`. On acceptance, `av_address`, `av_writedata` and the appropriate strobe are registered, and the state goes to ISSUE.
- **Transfer completion.** A transfer completes in an ISSUE cycle with `av_waitrequest == 0`. On completion:
  - If a new command is accepted in the same cycle, the block stays in ISSUE with the new command.
  - Otherwise it returns to IDLE and the strobes drop.
- **Stall.** While `av_waitrequest == 1` in ISSUE, all `av_*` outputs hold stable.
- **`cmd_ready`** is combinational and equals `!reset && (state == IDLE || !av_waitrequest) && (cmd_write || pending_ok)`.
- **`pending_ok`** is `pending < MAXPENDING`, or `pending == MAXPENDING && av_readdatavalid`.
- **Pending counter.**
  - +1 when a read is accepted.
  - −1 on `av_readdatavalid` when `pending > 0`.
  - Both in the same cycle: the count is unchanged.
  - The count never exceeds MAXPENDING and never wraps.
- **Writes** do not touch `pending`. A write may issue while reads are still pending; Avalon guarantees ordering.
- **Responses.** On `av_readdatavalid` with `pending > 0`:
  - `rsp_data <= av_readdata`; `rsp_valid <= 1` for one cycle.
  - Responses come out in read-issue order.
- **Spurious data.** `av_readdatavalid` with `pending == 0`:
  - No response is produced and `pending` stays 0.
  - `protocol_error <= 1`; it is cleared only by reset.
- **`av_readdatavalid` in IDLE** is legal and processed normally.

## Timing
- **Reset values.** While `reset` is high:
  - `av_read`, `av_write`, `rsp_valid`, `protocol_error` = 0.
  - `av_address`, `av_writedata`, `rsp_data`, `pending` = 0.
  - `cmd_ready` = 0.
  - State = IDLE.
- **Reset mid-transfer.** The strobe drops immediately (asynchronously) and `pending` clears. The slave must be reset alongside; read data arriving after reset sets `protocol_error`.
- **Accept to strobe.** A command accepted at edge N has its strobe high from edge N to the edge where it completes.
- **Minimum transfer length.** One cycle when `av_waitrequest == 0`.
- **Throughput.** One command per cycle when `av_waitrequest == 0` and `pending_ok` holds.
- **Read-data latency.** `av_readdatavalid` sampled at edge M gives `rsp_valid` high and `rsp_data` valid in the cycle after edge M.
- **Read gating.** With `pending == MAXPENDING`, a read command is not accepted, and `av_read` is not asserted for it, until a `av_readdatavalid` cycle. A write is still accepted.

## Test plan
- **Single write, no stall:** `cmd_write=1`, `addr=0x12`, `data=0xDEADBEEF`.
  - `av_write` is high for exactly one cycle with those values.
  - `pending` stays 0 and there is no `rsp_valid`.
- **Write stalled:** `av_waitrequest` high for 3 cycles.
  - `av_write`, `av_address` and `av_writedata` are stable for 4 cycles.
  - `cmd_ready` is low for the 3 stalled cycles.
  - A queued second command is accepted in the 4th cycle and issues back-to-back.
- **Five reads, slave data delayed:** MAXPENDING=4, five back-to-back reads to 0..4, slave returns 0xA0..0xA4 after 6 cycles.
  - Reads 0–3 issue on consecutive cycles; `pending` reaches 4.
  - The 5th read stalls (`cmd_ready=0`) until the first `av_readdatavalid`, then issues in that cycle.
  - `rsp_data` sequence is 0xA0, 0xA1, 0xA2, 0xA3, 0xA4; `pending` ends at 0.
- **Read accept coinciding with return:** `pending=2`, with read acceptance and `av_readdatavalid` in the same cycle.
  - `pending` stays 2 and one response is produced.
- **Spurious read data:** `av_readdatavalid` with `pending=0`.
  - No `rsp_valid`; `protocol_error` goes to 1 and stays 1 until reset.
- **Reset during stalled read:** assert `reset` during a stalled read with `pending=3`.
  - `av_read` drops in the same cycle; `pending=0`; `cmd_ready=0`.
  - After release, a new write completes normally.
